// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: opcodes, scoreboard entry
// layout and the source/entry match helper.
package hazard_scoreboard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } sb_entry_t;

    // A source only matches a live producer when the opcode really reads it; $0 never matches.
    function automatic logic src_hit(input sb_entry_t e, input logic [4:0] src, input logic used);
        return used & e.v & (src != REG_ZERO) & (e.rd == src);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Connection between the pipeline control path and the hazard scoreboard:
// ID instruction, issue information and the resulting hold/bubble/flush controls.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      inst;
    logic             issue_regwrite;
    logic             issue_memread;
    logic [4:0]       issue_rd;
    logic             branch_taken;
    logic             stall;
    logic             ifid_hold;
    logic             bubble;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output inst, issue_regwrite, issue_memread, issue_rd, branch_taken,
        input  stall, ifid_hold, bubble, ifid_flush, stall_cnt
    );

    modport slave (
        input  inst, issue_regwrite, issue_memread, issue_rd, branch_taken,
        output stall, ifid_hold, bubble, ifid_flush, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_src_decode.sv
// Opcode-to-operand-usage decode: which register sources the ID instruction reads
// and whether it is a branch consumer.
module hazard_src_decode
    import hazard_scoreboard_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       use_rs,
    output logic       use_rt,
    output logic       is_branch
);

    // Unknown opcodes read nothing so they can never stall on stale fields.
    always_comb begin
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_LW: begin
                use_rs = 1'b1;
            end
            OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BEQ: begin
                use_rs    = 1'b1;
                use_rt    = 1'b1;
                is_branch = 1'b1;
            end
            OP_ADDI: begin
                use_rs = 1'b1;
            end
            OP_J: begin
                use_rs = 1'b0;
            end
            default: begin
                use_rs    = 1'b0;
                use_rt    = 1'b0;
                is_branch = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / branch-operand hazard unit beside ID: an age-ordered shift register of
// in-flight producers decides how long the ID instruction must wait.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int LOAD_LAT  = 1,
    parameter int BRANCH_ID = 1,
    parameter int CNT_W     = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_scoreboard_if.slave hz
);

    localparam int DEPTH   = LOAD_LAT + 1;
    localparam int BR_XTRA = (BRANCH_ID != 0) ? 1 : 0;

    sb_entry_t        sb_r [DEPTH];
    sb_entry_t        sb_in_s;
    logic [4:0]       rs_s;
    logic [4:0]       rt_s;
    logic             use_rs_s;
    logic             use_rt_s;
    logic             is_branch_s;
    logic [DEPTH-1:0] window_s;
    logic [DEPTH-1:0] hit_s;
    logic             stall_s;
    logic [CNT_W-1:0] cnt_r;

    assign rs_s = hz.inst[25:21];
    assign rt_s = hz.inst[20:16];

    hazard_src_decode u_decode (
        .opcode    (hz.inst[31:26]),
        .use_rs    (use_rs_s),
        .use_rt    (use_rt_s),
        .is_branch (is_branch_s)
    );

    // Entry k was issued k+1 cycles ago; it blocks while k is still inside its latency window.
    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        localparam logic LD_PLAIN = (k < LOAD_LAT) ? 1'b1 : 1'b0;
        localparam logic LD_BR    = (k < LOAD_LAT + BR_XTRA) ? 1'b1 : 1'b0;
        localparam logic ALU_BR   = (k < BR_XTRA) ? 1'b1 : 1'b0;

        assign window_s[k] = sb_r[k].ld ? (is_branch_s ? LD_BR : LD_PLAIN)
                                        : (is_branch_s ? ALU_BR : 1'b0);
        assign hit_s[k]    = window_s[k] & (src_hit(sb_r[k], rs_s, use_rs_s) |
                                            src_hit(sb_r[k], rt_s, use_rt_s));
    end

    assign stall_s = |hit_s;

    // A stalled ID instruction does not issue, so the scoreboard receives a bubble.
    always_comb begin
        sb_in_s.v  = hz.issue_regwrite & ~stall_s & (hz.issue_rd != REG_ZERO);
        sb_in_s.rd = hz.issue_rd;
        sb_in_s.ld = hz.issue_memread;
    end

    // Age-ordered shift register; the oldest producer simply falls off the end.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_r[k] <= '{v: 1'b0, rd: 5'd0, ld: 1'b0};
            end
        end else begin
            sb_r[0] <= sb_in_s;
            for (int k = 1; k < DEPTH; k++) begin
                sb_r[k] <= sb_r[k-1];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A stall outranks a taken branch: the branch operand is not valid yet.
    assign hz.stall      = stall_s;
    assign hz.ifid_hold  = stall_s;
    assign hz.bubble     = stall_s;
    assign hz.ifid_flush = hz.branch_taken & ~stall_s;
    assign hz.stall_cnt  = cnt_r;

endmodule
